// File: rtl/tap_pkg.sv
// Shared TAP definitions: 1149.1 state encodings, opcodes and IR constants.
// Reset instruction depends on the TAP_IDCODE_EN build macro.
package tap_pkg;

   typedef enum logic [3:0] {
      TLR      = 4'hF,
      RTI      = 4'hC,
      SEL_DR   = 4'h7,
      CAP_DR   = 4'h6,
      SH_DR    = 4'h2,
      EX1_DR   = 4'h1,
      PAUSE_DR = 4'h3,
      EX2_DR   = 4'h0,
      UPD_DR   = 4'h5,
      SEL_IR   = 4'h4,
      CAP_IR   = 4'hE,
      SH_IR    = 4'hA,
      EX1_IR   = 4'h9,
      PAUSE_IR = 4'hB,
      EX2_IR   = 4'h8,
      UPD_IR   = 4'hD
   } tap_state_t;

   localparam logic [1:0] OP_EXTEST  = 2'b00;
   localparam logic [1:0] OP_SAMPLE  = 2'b01;
   localparam logic [1:0] OP_IDCODE  = 2'b10;
   localparam logic [1:0] OP_BYPASS  = 2'b11;
   localparam logic [1:0] IR_CAPTURE = 2'b01;

`ifdef TAP_IDCODE_EN
   localparam logic [1:0] IR_RESET = OP_IDCODE;
`else
   localparam logic [1:0] IR_RESET = OP_BYPASS;
`endif

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP controller state machine, advanced on TCK rising edge by TMS.
module tap_fsm
   import tap_pkg::*;
(
   input  logic       TCK,
   input  logic       TRST,
   input  logic       TMS,
   output tap_state_t state
);

   tap_state_t nxt;

   always_comb begin
      nxt = TLR;
      case (state)
         TLR:      nxt = TMS ? TLR    : RTI;
         RTI:      nxt = TMS ? SEL_DR : RTI;
         SEL_DR:   nxt = TMS ? SEL_IR : CAP_DR;
         CAP_DR:   nxt = TMS ? EX1_DR : SH_DR;
         SH_DR:    nxt = TMS ? EX1_DR : SH_DR;
         EX1_DR:   nxt = TMS ? UPD_DR : PAUSE_DR;
         PAUSE_DR: nxt = TMS ? EX2_DR : PAUSE_DR;
         EX2_DR:   nxt = TMS ? UPD_DR : SH_DR;
         UPD_DR:   nxt = TMS ? SEL_DR : RTI;
         SEL_IR:   nxt = TMS ? TLR    : CAP_IR;
         CAP_IR:   nxt = TMS ? EX1_IR : SH_IR;
         SH_IR:    nxt = TMS ? EX1_IR : SH_IR;
         EX1_IR:   nxt = TMS ? UPD_IR : PAUSE_IR;
         PAUSE_IR: nxt = TMS ? EX2_IR : PAUSE_IR;
         EX2_IR:   nxt = TMS ? UPD_IR : SH_IR;
         UPD_IR:   nxt = TMS ? SEL_DR : RTI;
         default:  nxt = TLR;
      endcase
   end

   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST) state <= TLR;
      else       state <= nxt;
   end

endmodule

// File: rtl/tap_controller.sv
// TAP controller: IR, bypass/ID data registers, boundary-chain control and TDO.
// Build macro TAP_IDCODE_EN adds the 32-bit ID register and makes IDCODE the reset instruction.
module tap_controller
   import tap_pkg::*;
#(
   parameter int          IR_W         = 2,
   parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
   input  logic            TCK,
   input  logic            TRST,
   input  logic            TMS,
   input  logic            TDI,
   input  logic            bsr_tdo,
   output logic            ShiftDR,
   output logic            ClockDR,
   output logic            UpdateDR,
   output logic            Mode,
   output logic [IR_W-1:0] ir,
   output logic [3:0]      tap_state,
   output logic            TDO,
   output logic            TDO_en
);

   tap_state_t      state;
   logic [IR_W-1:0] ir_shift;
   logic            bypass_reg;
   logic            sel_bsr;
   logic            sel_byp;
   logic            dr_lsb;
   logic            clkdr_en;

   tap_fsm u_fsm (
      .TCK   (TCK),
      .TRST  (TRST),
      .TMS   (TMS),
      .state (state)
   );

   assign tap_state = state;
   assign sel_bsr   = (ir == OP_EXTEST) || (ir == OP_SAMPLE);

   // Rising-edge capture/shift stage
   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST)                 ir_shift <= '0;
      else if (state == CAP_IR)  ir_shift <= IR_CAPTURE;
      else if (state == SH_IR)   ir_shift <= {TDI, ir_shift[IR_W-1:1]};
   end

   always_ff @(posedge TCK) begin
      if (sel_byp) begin
         if (state == CAP_DR)     bypass_reg <= 1'b0;
         else if (state == SH_DR) bypass_reg <= TDI;
      end
   end

`ifdef TAP_IDCODE_EN
   logic [31:0] id_reg;
   logic        sel_id;

   assign sel_id  = (ir == OP_IDCODE);
   assign sel_byp = !sel_bsr && !sel_id;
   assign dr_lsb  = sel_bsr ? bsr_tdo : (sel_id ? id_reg[0] : bypass_reg);

   always_ff @(posedge TCK) begin
      if (sel_id) begin
         if (state == CAP_DR)     id_reg <= IDCODE_VALUE;
         else if (state == SH_DR) id_reg <= {TDI, id_reg[31:1]};
      end
   end
`else
   logic unused_idcode;

   assign unused_idcode = ^IDCODE_VALUE;
   assign sel_byp = !sel_bsr;
   assign dr_lsb  = sel_bsr ? bsr_tdo : bypass_reg;
`endif

   // Falling-edge update/output stage
   always_ff @(negedge TCK or negedge TRST) begin
      if (!TRST)                ir <= IR_RESET;
      else if (state == UPD_IR) ir <= ir_shift;
      else if (state == TLR)    ir <= IR_RESET;
   end

   always_ff @(negedge TCK or negedge TRST) begin
      if (!TRST) begin
         ShiftDR  <= 1'b0;
         clkdr_en <= 1'b0;
         UpdateDR <= 1'b0;
         TDO_en   <= 1'b0;
         TDO      <= 1'b0;
      end else begin
         ShiftDR  <= sel_bsr && (state == SH_DR);
         clkdr_en <= sel_bsr && ((state == CAP_DR) || (state == SH_DR));
         UpdateDR <= sel_bsr && (state == UPD_DR);
         TDO_en   <= (state == SH_DR) || (state == SH_IR);
         if (state == SH_IR)      TDO <= ir_shift[0];
         else if (state == SH_DR) TDO <= dr_lsb;
         else                     TDO <= 1'b0;
      end
   end

   // Gated in the low phase only, so ClockDR cannot glitch; TRST kills it at once.
   assign ClockDR = TCK & clkdr_en;
   assign Mode    = (ir == OP_EXTEST);

endmodule

// File: tb/tb_tap_controller.sv
// Directed-vector bench for tap_controller; expectations follow the TAP_IDCODE_EN build macro.
module tb_tap_controller;

   logic       TCK;
   logic       TRST;
   logic       TMS;
   logic       TDI;
   logic       bsr_tdo;
   logic       ShiftDR;
   logic       ClockDR;
   logic       UpdateDR;
   logic       Mode;
   logic [1:0] ir;
   logic [3:0] tap_state;
   logic       TDO;
   logic       TDO_en;

   int checks   = 0;
   int failures = 0;
   int clkdr_cnt = 0;
   int shdr_cnt  = 0;
   int upd_cnt   = 0;

   localparam logic [31:0] ID_VAL = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
   localparam logic [1:0] IR_RST = 2'b10;
`else
   localparam logic [1:0] IR_RST = 2'b11;
`endif

   tap_controller #(.IR_W(2), .IDCODE_VALUE(ID_VAL)) dut (
      .TCK       (TCK),
      .TRST      (TRST),
      .TMS       (TMS),
      .TDI       (TDI),
      .bsr_tdo   (bsr_tdo),
      .ShiftDR   (ShiftDR),
      .ClockDR   (ClockDR),
      .UpdateDR  (UpdateDR),
      .Mode      (Mode),
      .ir        (ir),
      .tap_state (tap_state),
      .TDO       (TDO),
      .TDO_en    (TDO_en)
   );

   initial TCK = 1'b0;
   always #10 TCK = ~TCK;

   always @(posedge ClockDR) clkdr_cnt++;
   always @(posedge TCK) if (ShiftDR) shdr_cnt++;
   always @(posedge UpdateDR) upd_cnt++;

   // One TCK cycle; returns just after the falling edge so registered outputs are settled.
   task automatic step(input logic tms, input logic tdi);
      TMS = tms;
      TDI = tdi;
      @(posedge TCK);
      @(negedge TCK);
      #1;
   endtask

   task automatic load_ir(input logic [1:0] op);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, op[0]);
      step(1'b1, op[1]);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic test_reset;
      TRST = 1'b1; TMS = 1'b1; TDI = 1'b0; bsr_tdo = 1'b0;
      #5 TRST = 1'b0;
      #30;
      checks++; if (tap_state !== 4'hF) begin failures++; $display("FAIL reset_state got=%h exp=F", tap_state); end
      checks++; if (ir !== IR_RST) begin failures++; $display("FAIL reset_ir got=%b exp=%b", ir, IR_RST); end
      checks++; if ({Mode, TDO_en, TDO, ShiftDR, ClockDR, UpdateDR} !== 6'b0) begin
         failures++; $display("FAIL reset_outputs got=%b exp=000000", {Mode, TDO_en, TDO, ShiftDR, ClockDR, UpdateDR});
      end
      @(negedge TCK); #1 TRST = 1'b1;
      step(1'b0, 1'b0);
      checks++; if (tap_state !== 4'hC) begin failures++; $display("FAIL reset_to_rti got=%h exp=C", tap_state); end
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      checks++; if (tap_state !== 4'h2) begin failures++; $display("FAIL reach_shdr got=%h exp=2", tap_state); end
      repeat (5) step(1'b1, 1'b0);
      checks++; if (tap_state !== 4'hF) begin failures++; $display("FAIL tms5_to_tlr got=%h exp=F", tap_state); end
   endtask

   task automatic test_fsm_walk;
      logic       tms_v [20] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,
                                 1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0};
      logic [3:0] st_v  [20] = '{4'hC,4'h7,4'h6,4'h1,4'h3,4'h3,4'h0,4'h2,4'h1,4'h5,
                                 4'h7,4'h4,4'hE,4'h9,4'hB,4'h8,4'hA,4'h9,4'hD,4'hC};
      for (int i = 0; i < 20; i++) begin
         step(tms_v[i], 1'b1);
         checks++;
         if (tap_state !== st_v[i]) begin
            failures++; $display("FAIL walk_%0d got=%h exp=%h", i, tap_state, st_v[i]);
         end
      end
      // Capture 01 then a single shift of TDI=1 leaves 10 in the IR.
      checks++; if (ir !== 2'b10) begin failures++; $display("FAIL walk_ir got=%b exp=10", ir); end
   endtask

   task automatic test_ir_scan;
      step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      checks++; if ({TDO_en, TDO} !== 2'b11) begin failures++; $display("FAIL ir_tdo0 got=%b exp=11", {TDO_en, TDO}); end
      step(1'b0, 1'b0);
      checks++; if ({TDO_en, TDO} !== 2'b10) begin failures++; $display("FAIL ir_tdo1 got=%b exp=10", {TDO_en, TDO}); end
      step(1'b1, 1'b0);
      checks++; if ({TDO_en, TDO} !== 2'b00) begin failures++; $display("FAIL ir_exit_tdo got=%b exp=00", {TDO_en, TDO}); end
      step(1'b1, 1'b0);
      checks++; if (ir !== 2'b00 || Mode !== 1'b1) begin failures++; $display("FAIL ir_update got=%b/%b exp=00/1", ir, Mode); end
      step(1'b0, 1'b0);
   endtask

   task automatic test_bypass;
      logic tdi_v [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic exp_v [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      int c0;
      load_ir(2'b11);
      c0 = clkdr_cnt;
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({TDO_en, TDO, ShiftDR} !== {1'b1, exp_v[i], 1'b0}) begin
            failures++; $display("FAIL bypass_%0d got=%b exp=%b", i, {TDO_en, TDO, ShiftDR}, {1'b1, exp_v[i], 1'b0});
         end
         step(i == 3, tdi_v[i]);
      end
      step(1'b1, 1'b0);
      checks++; if (UpdateDR !== 1'b0) begin failures++; $display("FAIL bypass_upd got=%b exp=0", UpdateDR); end
      step(1'b0, 1'b0);
      checks++; if (clkdr_cnt - c0 !== 0) begin failures++; $display("FAIL bypass_clkdr got=%0d exp=0", clkdr_cnt - c0); end
   endtask

   task automatic test_sample_preload;
      logic [63:0] pat = 64'h0000_0002_A5F0_C3E1;
      int c0, s0, u0;
      load_ir(2'b01);
      checks++; if (ir !== 2'b01 || Mode !== 1'b0) begin failures++; $display("FAIL sp_ir got=%b/%b exp=01/0", ir, Mode); end
      c0 = clkdr_cnt; s0 = shdr_cnt; u0 = upd_cnt;
      step(1'b1, 1'b0); step(1'b0, 1'b0);
      bsr_tdo = pat[0];
      step(1'b0, 1'b0);
      for (int i = 0; i < 34; i++) begin
         checks++;
         if ({ShiftDR, TDO_en, TDO} !== {2'b11, pat[i]}) begin
            failures++; $display("FAIL sp_shift_%0d got=%b exp=%b", i, {ShiftDR, TDO_en, TDO}, {2'b11, pat[i]});
         end
         bsr_tdo = pat[i+1];
         step(i == 33, 1'b0);
      end
      step(1'b1, 1'b0);
      checks++; if (UpdateDR !== 1'b1) begin failures++; $display("FAIL sp_upd_high got=%b exp=1", UpdateDR); end
      step(1'b0, 1'b0);
      checks++; if (UpdateDR !== 1'b0) begin failures++; $display("FAIL sp_upd_low got=%b exp=0", UpdateDR); end
      checks++; if (clkdr_cnt - c0 !== 35) begin failures++; $display("FAIL sp_clkdr got=%0d exp=35", clkdr_cnt - c0); end
      checks++; if (shdr_cnt - s0 !== 34) begin failures++; $display("FAIL sp_shiftdr got=%0d exp=34", shdr_cnt - s0); end
      checks++; if (upd_cnt - u0 !== 1) begin failures++; $display("FAIL sp_upd_pulses got=%0d exp=1", upd_cnt - u0); end
   endtask

   task automatic test_tlr_reset;
      load_ir(2'b00);
      checks++; if (Mode !== 1'b1) begin failures++; $display("FAIL tlr_pre_mode got=%b exp=1", Mode); end
      repeat (5) step(1'b1, 1'b0);
      checks++; if (tap_state !== 4'hF || ir !== IR_RST || Mode !== 1'b0) begin
         failures++; $display("FAIL tlr_sync got=%h/%b/%b exp=F/%b/0", tap_state, ir, Mode, IR_RST);
      end
      step(1'b0, 1'b0);
   endtask

   task automatic test_idcode;
      logic [31:0] pat = 32'hA5C3_0F69;
      logic        exp;
      TRST = 1'b0;
      #2;
      @(negedge TCK); #1 TRST = 1'b1;
      checks++; if (ir !== IR_RST) begin failures++; $display("FAIL id_ir got=%b exp=%b", ir, IR_RST); end
      step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      for (int i = 0; i < 32; i++) begin
`ifdef TAP_IDCODE_EN
         exp = ID_VAL[i];
`else
         exp = (i == 0) ? 1'b0 : pat[i-1];
`endif
         checks++;
         if ({TDO_en, TDO} !== {1'b1, exp}) begin
            failures++; $display("FAIL id_bit_%0d got=%b exp=%b", i, {TDO_en, TDO}, {1'b1, exp});
         end
         step(i == 31, pat[i]);
      end
      step(1'b1, 1'b0); step(1'b0, 1'b0);
   endtask

   task automatic test_trst_mid_shift;
      int u0;
      load_ir(2'b00);
      u0 = upd_cnt;
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      step(1'b0, 1'b1); step(1'b0, 1'b0);
      checks++; if (ShiftDR !== 1'b1 || Mode !== 1'b1) begin failures++; $display("FAIL trst_pre got=%b/%b exp=1/1", ShiftDR, Mode); end
      TMS = 1'b0;
      @(posedge TCK);
      #3 TRST = 1'b0;
      #1;
      checks++; if (tap_state !== 4'hF) begin failures++; $display("FAIL trst_state got=%h exp=F", tap_state); end
      checks++; if ({ShiftDR, ClockDR, UpdateDR, Mode, TDO_en} !== 5'b0) begin
         failures++; $display("FAIL trst_outputs got=%b exp=00000", {ShiftDR, ClockDR, UpdateDR, Mode, TDO_en});
      end
      @(negedge TCK); #1 TRST = 1'b1;
      step(1'b0, 1'b0);
      checks++; if (ir !== IR_RST || upd_cnt - u0 !== 0) begin
         failures++; $display("FAIL trst_after got=%b/%0d exp=%b/0", ir, upd_cnt - u0, IR_RST);
      end
   endtask

   initial begin
      test_reset();
      test_fsm_walk();
      test_ir_scan();
      test_bypass();
      test_sample_preload();
      test_tlr_reset();
      test_idcode();
      test_trst_mid_shift();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1-style TAP controller that sequences the boundary-scan chains around the ripple adder.
- Decodes TMS into the 16-state TAP FSM and holds a 2-bit instruction register.
- Drives ShiftDR/ClockDR/UpdateDR/Mode into the input and output boundary-scan chains, owns the bypass register, and muxes the final TDO.
- Sits between the chip JTAG pins and the chain instances.

Parameters:
IR_W, 2, instruction register width (fixed opcode map below; must be 2)
IDCODE_VALUE, 32'h1000_0001, device ID returned by IDCODE; bit 0 must be 1 (only used with TAP_IDCODE_EN)

Ports:
TCK  input  1  test clock; sole clock, both edges used
TRST  input  1  asynchronous active-low test reset
TMS  input  1  mode select, sampled on TCK rising edge
TDI  input  1  serial data in (bypass/IDCODE/IR)
bsr_tdo  input  1  serial out of the last boundary-scan chain
ShiftDR  output  1  chain shift enable
ClockDR  output  1  chain capture/shift clock
UpdateDR  output  1  chain update clock
Mode  output  1  chain output-mux select (1 = EXTEST drive)
ir  output  IR_W  current (updated) instruction
tap_state  output  4  current FSM state, debug
TDO  output  1  serial data out
TDO_en  output  1  TDO output enable

Behaviour:
- Reset: TRST low asynchronously forces Test-Logic-Reset (TLR). ir=BYPASS (IDCODE when TAP_IDCODE_EN), IR shift reg=0. ShiftDR=ClockDR=UpdateDR=Mode=0, TDO=0, TDO_en=0.
- FSM: standard 16 states, advanced on TCK rising edge by TMS.
  - TLR -0-> RTI; RTI -1-> SelDR; SelDR -1-> SelIR / -0-> CapDR; CapDR -0-> ShDR / -1-> Ex1DR.
  - ShDR -1-> Ex1DR; Ex1DR -0-> PauseDR / -1-> UpdDR; PauseDR -1-> Ex2DR; Ex2DR -0-> ShDR / -1-> UpdDR.
  - UpdDR -0-> RTI / -1-> SelDR. SelIR -1-> TLR. IR branch mirrors the DR branch. All other TMS values hold or advance per 1149.1.
  - TMS=1 for 5 rising edges reaches TLR from any state.
  - Entering TLR synchronously applies the same ir value as TRST.
- Opcodes: 00 EXTEST, 01 SAMPLE_PRELOAD, 10 IDCODE, 11 BYPASS.
- Capture-IR loads 2'b01 into the IR shift register. Shift-IR shifts LSB-first from TDI. ir updates on the TCK falling edge in Update-IR.
- DR select:
  - EXTEST and SAMPLE_PRELOAD select the boundary chain.
  - BYPASS selects a 1-bit register; Capture-DR loads 0.
  - IDCODE selects the ID register when enabled, otherwise bypass.
- Chain control, only when the boundary chain is selected:
  - ShiftDR registered on TCK falling edge; 1 while the state is ShDR.
  - ClockDR = TCK AND clkdr_en. clkdr_en is registered on the falling edge, 1 in CapDR/ShDR. This gives exactly one rising ClockDR per TCK rising edge spent in those states.
  - UpdateDR = 1 for the low half of TCK in UpdDR: set on the falling edge, cleared on the next falling edge.
- Mode = 1 iff ir==EXTEST. It changes only with ir.
- TDO/TDO_en update on the TCK falling edge. TDO_en=1 only in ShDR/ShIR.
  - TDO source: IR LSB in ShIR; otherwise the selected DR LSB (bsr_tdo, bypass bit, or ID bit 0). TDO=0 when not enabled.
- Pause states: hold all shift registers. No ClockDR pulses.
- TRST asserted mid-shift: immediate TLR. ClockDR/UpdateDR forced low with no glitch beyond the current TCK-high phase. Chain contents are not updated.

Optional Feature:
TAP_IDCODE_EN
- Defined: 32-bit ID register; Capture-DR loads IDCODE_VALUE; shifts LSB-first. Reset/TLR instruction = IDCODE.
- Undefined: no ID register; opcode 10 behaves exactly as BYPASS; reset instruction = BYPASS.

Decomposition:
- Package tap_pkg: 4-bit state typedef with 1149.1 conventional encodings (TLR=4'hF, RTI=4'hC, SelDR=4'h7, CapDR=4'h6, ShDR=4'h2, Ex1DR=4'h1, PauseDR=4'h3, Ex2DR=4'h0, UpdDR=4'h5, SelIR=4'h4, CapIR=4'hE, ShIR=4'hA, Ex1IR=4'h9, PauseIR=4'hB, Ex2IR=4'h8, UpdIR=4'hD), opcode constants, IR capture constant.
- Sub-module tap_fsm: state register plus next-state logic (TCK, TRST, TMS -> state). tap_controller adds the IR, DR muxing and negedge output stage.

Test Plan:
- TRST low at any state -> tap_state=4'hF, ir=2'b11, Mode=0, TDO_en=0; then TMS=1 x5 from ShDR -> 4'hF.
- IR scan shifting 2'b00 (TMS 0,1,1,0,0, TDI 0,0, exit/update) -> TDO reads 1,0 (capture 01); after Update-IR falling edge, ir=00 and Mode=1.
- BYPASS, shift DR with TDI=1,0,1,1 -> TDO=0,1,0,1 (one-cycle delay, leading capture 0); ClockDR stays 0.
- SAMPLE_PRELOAD, Capture-DR + 34 Shift-DR cycles (N=16 in/out chains) -> 35 ClockDR rising edges, ShiftDR=1 for 34, one UpdateDR pulse, TDO follows bsr_tdo.
- TAP_IDCODE_EN: after TRST, DR scan 32 bits -> TDO yields IDCODE_VALUE LSB-first; without macro, same scan -> single 0 then TDI delayed.
- TRST asserted during ShDR of EXTEST -> same-cycle ShiftDR/UpdateDR=0, Mode=0, no UpdateDR pulse.
